psram_qspi_responder: RTL

PSRAM_QSPI_RESPONDER -- requirements
Module: psram_qspi_responder

---
 rtl/psram_qspi_responder.sv | 296 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder
// Slave-side model of a QSPI/QPI PSRAM device that sits behind a simple byte-wide memory port.
// Every input from the controller (sck, ce_n, io_i) is asynchronous to HCLK. Each one passes
// through a two-flop synchronizer. sck edges come from comparing the synchronized copy with
// its previous value.
// Supported commands:
//   0xEB  quad read, with WAIT_CYCLES dummy clocks
//   0x38  quad write
//   0x35  enter QPI
//   0xF5  exit QPI
// Any other command is ignored until ce_n rises.
//
// Memory port protocol:
//   mem_re  one-HCLK strobe. mem_addr is valid in the same cycle. The memory returns mem_rdata
//           on the next HCLK, and this block captures it one cycle after the strobe.
//   mem_we  one-HCLK strobe. mem_addr and mem_wdata are valid in the same cycle.
//   No back-pressure exists. The two strobes are never high in the same cycle.

module psram_qspi_responder #(
   parameter int ADDR_W      = 16,
   parameter int WAIT_CYCLES = 6
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              sck,
   input  logic              ce_n,
   input  logic [3:0]        io_i,
   output logic [3:0]        io_o,
   output logic [3:0]        io_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              qpi_mode,
   output logic [2:0]        o_dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RDATA  = 3'd4,
      ST_WDATA  = 3'd5,
      ST_IGNORE = 3'd6
   } state_t;

   // Last dummy-cycle index; a zero-wait build skips WAIT entirely
   localparam logic [7:0] LP_WAIT_LAST = 8'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

   // Synchronizer stages plus the previous-value flops used for edge detection
   logic              r_sck_m, r_sck_s, r_sck_d;
   logic              r_ce_m, r_ce_s, r_ce_d;
   logic [3:0]        r_io_m, r_io_s;

   // Protocol state
   state_t            r_state;
   logic              r_qpi;
   logic [7:0]        r_cnt;
   logic              r_nib;
   logic [7:0]        r_shift;
   logic [ADDR_W-1:0] r_ashift;
   logic [ADDR_W-1:0] r_addr;
   logic              r_is_read;
   logic [7:0]        r_byte;
   logic              r_re_d;

   // Registered outputs
   logic [3:0]        r_io_o;
   logic [3:0]        r_io_oe;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_wdata;
   logic              r_mem_we;
   logic              r_mem_re;

   logic              w_sck_rise;
   logic              w_sck_fall;
   logic              w_ce_fall;
   logic [7:0]        w_cmd_spi;
   logic [7:0]        w_cmd_qpi;
   logic [7:0]        w_cmd;
   logic              w_cmd_last;
   logic [ADDR_W-1:0] w_addr_new;
   logic [ADDR_W-1:0] w_addr_inc;

   assign w_sck_rise = r_sck_s & ~r_sck_d;
   assign w_sck_fall = ~r_sck_s & r_sck_d;
   assign w_ce_fall  = r_ce_d & ~r_ce_s;

   // Command byte including the bit or nibble arriving on this rise
   assign w_cmd_spi  = 8'({r_shift, r_io_s[0]});
   assign w_cmd_qpi  = {r_shift[3:0], r_io_s};
   assign w_cmd      = r_qpi ? w_cmd_qpi : w_cmd_spi;
   assign w_cmd_last = r_qpi ? (r_cnt == 8'd1) : (r_cnt == 8'd7);

   // The address shifter keeps only the low ADDR_W bits of the 24-bit wire address
   assign w_addr_new = ADDR_W'({r_ashift, r_io_s});
   assign w_addr_inc = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

   assign io_o        = r_io_o;
   assign io_oe       = r_io_oe;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign mem_we      = r_mem_we;
   assign mem_re      = r_mem_re;
   assign qpi_mode    = r_qpi;
   assign o_dbg_state = r_state;

   // Two-flop synchronizers for the controller-side signals plus one delay stage for edges
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sck_m <= 1'b0;
         r_sck_s <= 1'b0;
         r_sck_d <= 1'b0;
         r_ce_m  <= 1'b1;
         r_ce_s  <= 1'b1;
         r_ce_d  <= 1'b1;
         r_io_m  <= 4'h0;
         r_io_s  <= 4'h0;
      end else begin
         r_sck_m <= sck;
         r_sck_s <= r_sck_m;
         r_sck_d <= r_sck_s;
         r_ce_m  <= ce_n;
         r_ce_s  <= r_ce_m;
         r_ce_d  <= r_ce_s;
         r_io_m  <= io_i;
         r_io_s  <= r_io_m;
      end
   end

   // Transaction FSM: command, address, dummy and data phases with registered outputs
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_qpi       <= 1'b0;
         r_cnt       <= 8'd0;
         r_nib       <= 1'b0;
         r_shift     <= 8'h00;
         r_ashift    <= '0;
         r_addr      <= '0;
         r_is_read   <= 1'b0;
         r_byte      <= 8'h00;
         r_re_d      <= 1'b0;
         r_io_o      <= 4'h0;
         r_io_oe     <= 4'h0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 8'h00;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
      end else begin
         // Strobes last a single cycle unless a branch below raises them again
         r_mem_we <= 1'b0;
         r_mem_re <= 1'b0;
         r_re_d   <= r_mem_re;
         // Capture read data one cycle after each read strobe
         if (r_re_d) begin
            r_byte <= mem_rdata;
         end

         if (r_ce_s) begin
            // Deselect overrides everything, including an sck edge seen in this same cycle
            r_state <= ST_IDLE;
            r_io_oe <= 4'h0;
            r_cnt   <= 8'd0;
            r_nib   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_ce_fall) begin
                     r_state <= ST_CMD;
                     r_cnt   <= 8'd0;
                     r_nib   <= 1'b0;
                  end
               end

               ST_CMD: begin
                  if (w_sck_rise) begin
                     r_shift <= w_cmd;
                     if (w_cmd_last) begin
                        r_cnt    <= 8'd0;
                        r_ashift <= '0;
                        case (w_cmd)
                           8'hEB: begin
                              r_is_read <= 1'b1;
                              r_state   <= ST_ADDR;
                           end
                           8'h38: begin
                              r_is_read <= 1'b0;
                              r_state   <= ST_ADDR;
                           end
                           8'h35: begin
                              r_qpi   <= 1'b1;
                              r_state <= ST_IGNORE;
                           end
                           8'hF5: begin
                              r_qpi   <= 1'b0;
                              r_state <= ST_IGNORE;
                           end
                           default: r_state <= ST_IGNORE;
                        endcase
                     end else begin
                        r_cnt <= r_cnt + 8'd1;
                     end
                  end
               end

               ST_ADDR: begin
                  if (w_sck_rise) begin
                     r_ashift <= w_addr_new;
                     if (r_cnt == 8'd5) begin
                        r_cnt  <= 8'd0;
                        r_nib  <= 1'b0;
                        r_addr <= w_addr_new;
                        if (r_is_read) begin
                           // Fetch the first byte now so that it is ready before the first data fall
                           r_mem_re   <= 1'b1;
                           r_mem_addr <= w_addr_new;
                           if (WAIT_CYCLES == 0) begin
                              r_state <= ST_RDATA;
                              r_io_oe <= 4'hF;
                           end else begin
                              r_state <= ST_WAIT;
                           end
                        end else begin
                           r_state <= ST_WDATA;
                        end
                     end else begin
                        r_cnt <= r_cnt + 8'd1;
                     end
                  end
               end

               ST_WAIT: begin
                  r_io_oe <= 4'h0;
                  if (w_sck_rise) begin
                     if (r_cnt == LP_WAIT_LAST) begin
                        r_state <= ST_RDATA;
                        r_io_oe <= 4'hF;
                        r_cnt   <= 8'd0;
                        r_nib   <= 1'b0;
                     end else begin
                        r_cnt <= r_cnt + 8'd1;
                     end
                  end
               end

               ST_RDATA: begin
                  r_io_oe <= 4'hF;
                  if (w_sck_fall) begin
                     if (!r_nib) begin
                        r_io_o <= r_byte[7:4];
                        r_nib  <= 1'b1;
                     end else begin
                        // After the low nibble goes out, prefetch the next byte (address wraps)
                        r_io_o     <= r_byte[3:0];
                        r_nib      <= 1'b0;
                        r_addr     <= w_addr_inc;
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_addr_inc;
                     end
                  end
               end

               ST_WDATA: begin
                  r_io_oe <= 4'h0;
                  if (w_sck_rise) begin
                     if (!r_nib) begin
                        r_shift[3:0] <= r_io_s;
                        r_nib        <= 1'b1;
                     end else begin
                        // A byte is written only once both nibbles have arrived
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= {r_shift[3:0], r_io_s};
                        r_addr      <= w_addr_inc;
                        r_nib       <= 1'b0;
                     end
                  end
               end

               ST_IGNORE: begin
                  r_io_oe <= 4'h0;
               end

               default: begin
                  r_state <= ST_IDLE;
                  r_io_oe <= 4'h0;
               end
            endcase
         end
      end
   end

endmodule
